uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter clocked by the divided clock (`o_div_clk` of `clock_divider`), which is its only clock. It accepts a parallel word with a single-cycle valid strobe and shifts out one UART frame: start bit, data LSB first, optional parity, stop bit. It sits directly downstream of the clock divider. Every bit occupies exactly one `i_clk` cycle, so the divider ratio sets the baud rate.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `i_clk`  in  1: transmit clock, driven by `clock_divider.o_div_clk`.
- `i_rst`  in  1: reset, synchronous, active-low.
- `i_data`  in  DATA_WIDTH: word to send; sampled only on acceptance.
- `i_data_valid`  in  1: request strobe; honoured only in IDLE.
- `i_par_en`  in  1: 1 appends a parity bit; sampled on acceptance.
- `i_par_typ`  in  1: 0 selects even parity, 1 selects odd; sampled on acceptance.
- `o_tx_out`  out  1: serial line, registered; idles high.
- `o_busy`  out  1: high while a frame is in progress (any state other than IDLE), registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `o_tx_out`=1, `o_busy`=0.
  - If `i_data_valid`=1 at a rising edge, latch `i_data`, `i_par_en` and `i_par_typ` into shadow registers and go to START.
- START: `o_tx_out`=0 for one cycle, then DATA.
- DATA:
  - Drive the shadow word LSB first, one bit per cycle.
  - A bit counter runs 0..DATA_WIDTH-1.
  - When the counter reaches DATA_WIDTH-1, go to PARITY if `par_en` is set, otherwise to STOP.
- PARITY:
  - Even parity bit = XOR-reduce of the shadow word.
  - Odd parity bit = its inverse.
  - Lasts one cycle, then STOP.
- STOP: `o_tx_out`=1 for one cycle, then IDLE.
- `o_busy`=1 in START, DATA, PARITY and STOP.
- `i_data_valid` is ignored whenever the state is not IDLE. There is no queueing, and the dropped request has no side effect on the shadow registers.
- Changes to `i_data`, `i_par_en` or `i_par_typ` mid-frame have no effect on the frame in progress.
- Bit counter width is `$clog2(DATA_WIDTH)`. The counter resets to 0 on entry to DATA and never wraps past DATA_WIDTH-1.

## Timing
- Reset (`i_rst`=0 at an edge):
  - state=IDLE, `o_tx_out`=1, `o_busy`=0, counter=0, shadow registers=0.
  - Applies in any state. A frame cut short by reset is abandoned, and the line returns high on the same edge.
- If reset and valid are both present at the same edge, reset wins and the request is lost.
- Latency: valid sampled at edge N; start bit and `o_busy`=1 are visible after edge N.
- Frame length in cycles:
  - Parity disabled: DATA_WIDTH+2 (10 at default width).
  - Parity enabled: DATA_WIDTH+3 (11 at default width).
- After the stop bit there is one edge back to IDLE. A valid sampled at that edge, with `o_busy` already 0, starts the next frame.
- Minimum spacing from one start bit to the next: frame length + 1 cycle.
- Holding `i_data_valid` high continuously sends repeated frames at that spacing.
- `i_data_valid` is an upstream pulse. The upstream source must either watch `o_busy` or accept that its request is dropped.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (3-bit encoding);
  - constants `PAR_EVEN`=1'b0 and `PAR_ODD`=1'b1;
  - `UART_IDLE_LEVEL`=1'b1.
- One natural sub-module is `uart_parity_calc`: a parameterised, purely combinational XOR-reduce with odd/even select. The UART RX reuses it later.
- Output multiplexing by state is done in the top. `o_tx_out` and `o_busy` are flopped.

## Test plan
- Reset: hold `i_rst`=0 for 2 cycles mid-frame, then release. Required: `o_tx_out`=1 and `o_busy`=0 on the first reset edge; no residual bits afterwards.
- 0xA5, `i_par_en`=0. Required:
  - line sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles;
  - `o_busy` high for exactly 10 cycles.
- 0xA5, parity enabled:
  - even parity: sequence 0,1,0,1,0,0,1,0,1,0(parity),1, over 11 cycles;
  - odd parity: the parity bit is 1.
- 0x07, even parity: parity bit=1 (popcount 3).
- Valid pulsed with 0x3C during the DATA state of a 0xFF frame. Required: the 0xFF frame is unchanged, no 0x3C frame follows, and the line stays high afterwards.
- `i_data_valid` held high with 0x55, parity off, for 30 cycles. Required:
  - start bits 11 cycles apart;
  - `o_busy` low for exactly one cycle between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity select values, line idle level.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN        = 1'b0;
  localparam logic PAR_ODD         = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Bit counter width; a 1-bit payload still needs a 1-bit counter.
  function automatic int unsigned uart_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the word, inverted for odd parity.
// Zero latency, no flow control.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par_bit
);

  assign o_par_bit = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, stop bit, one bit per i_clk.
// Start bit visible one edge after valid; requests arriving while o_busy is high are dropped, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = uart_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q,      tx_d;
  logic                  busy_q,    busy_d;
  logic                  par_bit;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data    (data_q),
    .i_par_typ (par_typ_q),
    .o_par_bit (par_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_data_valid) begin
          state_d   = ST_START;
          data_d    = i_data;
          par_en_d  = i_par_en;
          par_typ_d = i_par_typ;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the line changes on the same edge as the state.
  always_comb begin
    tx_d   = UART_IDLE_LEVEL;
    busy_d = 1'b1;
    unique case (state_d)
      ST_IDLE: begin
        tx_d   = UART_IDLE_LEVEL;
        busy_d = 1'b0;
      end
      ST_START:  tx_d = ~UART_IDLE_LEVEL;
      ST_DATA:   tx_d = data_d[cnt_d];
      ST_PARITY: tx_d = par_bit;
      ST_STOP:   tx_d = UART_IDLE_LEVEL;
      default: begin
        tx_d   = UART_IDLE_LEVEL;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame bit sequences, parity, dropped requests, reset, back-to-back frames.
module tb_uart_tx;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_par_en;
  logic       i_par_typ;
  logic       o_tx_out;
  logic       o_busy;

  int n_checks;
  int n_errors;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_par_en     (i_par_en),
    .i_par_typ    (i_par_typ),
    .o_tx_out     (o_tx_out),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; outputs are read 1ns later, inputs change there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      check_eq({tag, " idle tx"},   {31'd0, o_tx_out}, 32'd1);
      check_eq({tag, " idle busy"}, {31'd0, o_busy},   32'd0);
      tick();
    end
  endtask

  // seq is written in transmit order left to right: cycle k is seq[len-1-k].
  // inject_at >= 0 pulses a 0x3C request at the edge after cycle inject_at.
  task automatic send_frame(input string tag, input logic [7:0] data, input logic par_en,
                            input logic par_typ, input logic [10:0] seq, input int len,
                            input int inject_at);
    i_data       = data;
    i_par_en     = par_en;
    i_par_typ    = par_typ;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    i_data       = ~data;
    i_par_en     = ~par_en;
    i_par_typ    = ~par_typ;
    for (int k = 0; k < len; k++) begin
      check_eq($sformatf("%s bit%0d", tag, k), {31'd0, o_tx_out}, {31'd0, seq[len-1-k]});
      check_eq($sformatf("%s busy%0d", tag, k), {31'd0, o_busy}, 32'd1);
      if (k == inject_at) begin
        i_data       = 8'h3C;
        i_data_valid = 1'b1;
      end
      tick();
      i_data_valid = 1'b0;
    end
    check_eq({tag, " end tx"},   {31'd0, o_tx_out}, 32'd1);
    check_eq({tag, " end busy"}, {31'd0, o_busy},   32'd0);
  endtask

  initial begin
    logic [10:0] rep;
    n_checks     = 0;
    n_errors     = 0;
    i_rst        = 1'b0;
    i_data       = 8'h00;
    i_data_valid = 1'b0;
    i_par_en     = 1'b0;
    i_par_typ    = 1'b0;
    tick();
    tick();
    check_eq("reset tx",   {31'd0, o_tx_out}, 32'd1);
    check_eq("reset busy", {31'd0, o_busy},   32'd0);
    i_rst = 1'b1;
    tick();
    check_idle("post reset", 2);

    send_frame("a5 nopar",  8'hA5, 1'b0, 1'b0, 11'b00101001011, 10, -1);
    tick();
    send_frame("a5 even",   8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, -1);
    tick();
    send_frame("a5 odd",    8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, -1);
    tick();
    send_frame("07 even",   8'h07, 1'b1, 1'b0, 11'b01110000011, 11, -1);
    tick();
    send_frame("ff drop3c", 8'hFF, 1'b0, 1'b0, 11'b00111111111, 10, 3);
    check_idle("after drop", 12);

    // Reset mid-frame on an all-zero word, with a request present on the first reset edge.
    i_data       = 8'h00;
    i_par_en     = 1'b0;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    check_eq("mid start tx", {31'd0, o_tx_out}, 32'd0);
    tick();
    tick();
    check_eq("mid data tx",  {31'd0, o_tx_out}, 32'd0);
    i_rst        = 1'b0;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    check_eq("rst edge1 tx",   {31'd0, o_tx_out}, 32'd1);
    check_eq("rst edge1 busy", {31'd0, o_busy},   32'd0);
    tick();
    check_eq("rst edge2 tx",   {31'd0, o_tx_out}, 32'd1);
    check_eq("rst edge2 busy", {31'd0, o_busy},   32'd0);
    i_rst = 1'b1;
    tick();
    check_idle("after rst", 12);

    // Continuous valid with 0x55: 10-cycle frame plus one idle cycle, repeating.
    rep          = 11'b01010101011;
    i_data       = 8'h55;
    i_par_en     = 1'b0;
    i_data_valid = 1'b1;
    tick();
    for (int c = 0; c < 30; c++) begin
      check_eq($sformatf("rep tx%0d", c),   {31'd0, o_tx_out}, {31'd0, rep[10 - (c % 11)]});
      check_eq($sformatf("rep busy%0d", c), {31'd0, o_busy},   {31'd0, ((c % 11) != 10)});
      tick();
    end
    i_data_valid = 1'b0;
    for (int c = 30; c < 33; c++) begin
      check_eq($sformatf("rep tx%0d", c),   {31'd0, o_tx_out}, {31'd0, rep[10 - (c % 11)]});
      check_eq($sformatf("rep busy%0d", c), {31'd0, o_busy},   {31'd0, ((c % 11) != 10)});
      tick();
    end
    check_idle("rep drain", 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
